roman_symbol_streamer: RTL and testbench
========================================

# roman_symbol_streamer

Sequential controller around the combinational `bin2roman_base10` converter. It accepts one binary value at a time over a valid/ready handshake, then schedules the shared converter through a tens phase and a units phase. It streams the resulting Roman symbols one per beat, most significant first, on a valid/ready output with a last flag. Splitting the value into two phases makes the full 7-symbol form of 38 (XXXVIII) available, which a single 6-slot conversion cannot hold. It sits between the number source and the symbol display/encoder.

## Interface
- `BIT_WIDTH`, 6: input value width; the legal range is 0..63.
- `OUT_NUM`, 6: symbol slots per converter result.
- `OUT_WIDTH`, 3: symbol code width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block is idle and can accept a value.
- `in_data`  in  BIT_WIDTH  value to convert.
- `sym_valid`  out  1  `sym_data` is valid.
- `sym_ready`  in  1  downstream accepts the symbol.
- `sym_data`  out  OUT_WIDTH  symbol code: NULL=0, I=1, V=2, X=3, L=4.
- `sym_last`  out  1  current beat is the final symbol of the number.
- `busy`  out  1  high in every state except IDLE.

## Operation
- State register values: IDLE, TENS_LD, TENS_EMIT, UNITS_LD, UNITS_EMIT, ZERO.
- Accept: a value is accepted when `in_valid & in_ready`. On that edge:
  - latch `t = in_data / 10` and `u = in_data % 10`;
  - next state is TENS_LD if t≠0, else UNITS_LD if u≠0, else ZERO.
- Converter input mux:
  - in TENS_LD the converter is driven with `t*10`;
  - in UNITS_LD it is driven with `u`;
  - otherwise it is driven with 0.
- LD states (one cycle each):
  - register the 18-bit converter word into `symbuf`;
  - set `cnt` = index of the highest non-NULL slot + 1 (range 1..4; a NULL result is never loaded);
  - go to the matching EMIT state.
- EMIT states:
  - `sym_valid` = 1 and `sym_data` = `symbuf` slot `cnt-1`. Slot 0 is bits [2:0] and is emitted last.
  - On a beat (`sym_valid & sym_ready`), `cnt` decrements.
  - A beat taken with `cnt`=1 ends the phase:
    - TENS_EMIT goes to UNITS_LD if u≠0, else IDLE;
    - UNITS_EMIT goes to IDLE.
- `sym_last` = 1 on the beat with `cnt`=1 when either:
  - the state is UNITS_EMIT, or
  - the state is TENS_EMIT and u=0.
- ZERO state:
  - drives a single beat with `sym_data`=NULL and `sym_last`=1;
  - goes to IDLE on handshake.
- `in_ready` = (state==IDLE). No new value is accepted while a stream is in progress.

## Timing
- Reset values: state=IDLE, `sym_valid`=0, `sym_data`=0, `sym_last`=0, `busy`=0, `in_ready`=1, `cnt`=0, `symbuf`=0.
- Asserting `rst` mid-stream aborts the stream immediately with no partial last beat. The first accept is possible in the first cycle after deassertion.
- Latency: accept on edge E0 → state is LD during the next cycle → `sym_valid` rises after edge E1 (first symbol visible in the second cycle after the accept cycle).
- With `sym_ready` held at 1:
  - one symbol per cycle within a phase;
  - exactly one bubble cycle (UNITS_LD) between the tens and units phases.
- Backpressure: while `sym_valid & !sym_ready`, `sym_data` and `sym_last` hold stable and `cnt` does not change.
- `sym_data`, `sym_last` and `sym_valid` are decoded from registered state only, with no combinational path from `sym_ready`.
- After the final beat the state is IDLE, so `in_ready` returns the following cycle. Minimum period per number is symbols + phases + 1 cycles.

## Structure
- Shared package `roman_pkg` holds:
  - the symbol code constants SYM_NULL/I/V/X/L;
  - the state enumeration;
  - the `OUT_NUM` and `OUT_WIDTH` constants.
- One sub-module: a single instance of `bin2roman_base10`, used for both phases.
- The divide and modulo by 10 are on a 6-bit value and stay in this block as combinational logic on accept.

## Test plan
- 14, ready=1 → accept, then beats X, I, V on consecutive cycles after one LD cycle; `sym_last` only on V; one bubble before I.
- 38 → seven beats X, X, X, V, I, I, I; one bubble between the third X and V; `sym_last` only on the final I.
- 0 → a single beat NULL with `sym_last`=1; `in_ready` high again one cycle later.
- 50 → a single beat L with `sym_last`=1; no units phase runs.
- 4 with `sym_ready`=0 for 5 cycles → I is held stable with `cnt` unchanged, then I and V follow when ready rises; `in_valid` offered mid-stream is not accepted.
- Assert `rst` during the units phase of 38 → `sym_valid` drops immediately and `in_ready`=1; after release, 9 streams I, X with `sym_last` on X.

Source files
------------

// File: rtl/roman_pkg.sv
// ---------------------------------------------------------------------------
// roman_pkg
// Shared definitions for the Roman symbol streamer:
//   - symbol codes emitted on the symbol stream (NULL, I, V, X, L)
//   - controller state enumeration
//   - converter geometry (OUT_NUM slots of OUT_WIDTH bits)
//   - digit_syms/digit_len: symbol pattern of one decimal digit
// ---------------------------------------------------------------------------
package roman_pkg;

    localparam int OUT_NUM   = 6;
    localparam int OUT_WIDTH = 3;

    localparam logic [OUT_WIDTH-1:0] SYM_NULL = 3'd0;
    localparam logic [OUT_WIDTH-1:0] SYM_I    = 3'd1;
    localparam logic [OUT_WIDTH-1:0] SYM_V    = 3'd2;
    localparam logic [OUT_WIDTH-1:0] SYM_X    = 3'd3;
    localparam logic [OUT_WIDTH-1:0] SYM_L    = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        TENS_LD    = 3'd1,
        TENS_EMIT  = 3'd2,
        UNITS_LD   = 3'd3,
        UNITS_EMIT = 3'd4,
        ZERO       = 3'd5
    } state_t;

    // Symbols of one decimal digit, packed into four slots. Slot 0 (the
    // low bits) holds the symbol written last, so the string reads from
    // the highest occupied slot down to slot 0.
    function automatic logic [4*OUT_WIDTH-1:0] digit_syms(
        input logic [3:0]           d,
        input logic [OUT_WIDTH-1:0] one,
        input logic [OUT_WIDTH-1:0] five,
        input logic [OUT_WIDTH-1:0] ten
    );
        logic [4*OUT_WIDTH-1:0] s;
        case (d)
            4'd1:    s = {9'b0, one};
            4'd2:    s = {6'b0, one, one};
            4'd3:    s = {3'b0, one, one, one};
            4'd4:    s = {6'b0, one, five};
            4'd5:    s = {9'b0, five};
            4'd6:    s = {6'b0, five, one};
            4'd7:    s = {3'b0, five, one, one};
            4'd8:    s = {five, one, one, one};
            4'd9:    s = {6'b0, one, ten};
            default: s = '0;
        endcase
        return s;
    endfunction

    // Number of symbols produced by digit_syms for the same digit.
    function automatic logic [2:0] digit_len(input logic [3:0] d);
        logic [2:0] n;
        case (d)
            4'd1, 4'd5:             n = 3'd1;
            4'd2, 4'd4, 4'd6, 4'd9: n = 3'd2;
            4'd3, 4'd7:             n = 3'd3;
            4'd8:                   n = 3'd4;
            default:                n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/roman_symbol_streamer_if.sv
// ---------------------------------------------------------------------------
// roman_symbol_streamer_if
// Handshake bundle of the Roman symbol streamer.
//   in_valid/in_ready/in_data           : binary value input (valid/ready)
//   sym_valid/sym_ready/sym_data/sym_last : symbol output stream
// Modports:
//   slave  - the streamer (consumes values, produces symbols)
//   master - the environment (produces values, consumes symbols)
// ---------------------------------------------------------------------------
interface roman_symbol_streamer_if #(
    parameter int BIT_WIDTH = 6,
    parameter int OUT_WIDTH = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] in_data;
    logic                 sym_valid;
    logic                 sym_ready;
    logic [OUT_WIDTH-1:0] sym_data;
    logic                 sym_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  sym_ready,
        output in_ready,
        output sym_valid,
        output sym_data,
        output sym_last
    );

    modport master (
        output in_valid,
        output in_data,
        output sym_ready,
        input  in_ready,
        input  sym_valid,
        input  sym_data,
        input  sym_last
    );
endinterface

// File: rtl/bin2roman_base10.sv
// ---------------------------------------------------------------------------
// bin2roman_base10
// Combinational binary -> Roman symbol converter.
//   value : binary input (0..63)
//   roman : OUT_NUM slots of OUT_WIDTH bits; slot 0 (bits [2:0]) holds the
//           last symbol, unused upper slots are NULL.
// A value needing more than OUT_NUM symbols (38 = XXXVIII) loses its most
// significant symbol; the streamer avoids this by converting tens and
// units separately.
// ---------------------------------------------------------------------------
module bin2roman_base10
    import roman_pkg::*;
#(
    parameter int BIT_WIDTH = 6,
    parameter int OUT_NUM   = roman_pkg::OUT_NUM,
    parameter int OUT_WIDTH = roman_pkg::OUT_WIDTH
) (
    input  logic [BIT_WIDTH-1:0]         value,
    output logic [OUT_NUM*OUT_WIDTH-1:0] roman
);

    localparam int RW  = OUT_NUM * OUT_WIDTH;
    localparam int EXT = 8 * OUT_WIDTH;

    logic [3:0]             tens;
    logic [3:0]             units;
    logic [4*OUT_WIDTH-1:0] tens_syms;
    logic [4*OUT_WIDTH-1:0] units_syms;
    logic [4:0]             shamt;

    always_comb begin
        tens       = 4'(value / BIT_WIDTH'(10));
        units      = 4'(value % BIT_WIDTH'(10));
        // Tens digit never exceeds 6 for a 6-bit value, so no C is needed.
        tens_syms  = digit_syms(tens, SYM_X, SYM_L, SYM_NULL);
        units_syms = digit_syms(units, SYM_I, SYM_V, SYM_X);
        // Tens symbols sit directly above the units symbols.
        shamt      = 5'(digit_len(units)) * 5'(OUT_WIDTH);
        roman      = RW'(EXT'(units_syms) | (EXT'(tens_syms) << shamt));
    end

endmodule

// File: rtl/roman_symbol_streamer.sv
// ---------------------------------------------------------------------------
// roman_symbol_streamer
// Accepts one binary value (0..63), converts its tens and units digits in
// two phases through one shared bin2roman_base10, and streams the Roman
// symbols most significant first, one per beat, with a last flag.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of roman_symbol_streamer_if (value in, symbols out)
//   busy : high whenever the controller is not idle
// ---------------------------------------------------------------------------
module roman_symbol_streamer
    import roman_pkg::*;
#(
    parameter int BIT_WIDTH = 6,
    parameter int OUT_NUM   = roman_pkg::OUT_NUM,
    parameter int OUT_WIDTH = roman_pkg::OUT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    roman_symbol_streamer_if.slave  bus,
    output logic                    busy
);

    localparam int RW = OUT_NUM * OUT_WIDTH;

    state_t               state_reg, state_next;
    logic [2:0]           t_reg, t_next;
    logic [3:0]           u_reg, u_next;
    logic [RW-1:0]        symbuf_reg, symbuf_next;
    logic [2:0]           cnt_reg, cnt_next;

    logic [BIT_WIDTH-1:0] conv_in;
    logic [RW-1:0]        conv_out;
    logic [OUT_NUM-1:0]   slot_nonnull;
    logic [2:0]           top_cnt;
    logic [OUT_WIDTH-1:0] slot_arr [OUT_NUM];
    logic [2:0]           slot_sel;
    logic [OUT_WIDTH-1:0] cur_sym;
    logic                 emit;
    logic                 last_slot;
    logic                 beat;

    // Shared converter: tens phase sees t*10, units phase sees u.
    always_comb begin
        case (state_reg)
            TENS_LD:  conv_in = BIT_WIDTH'(t_reg) * BIT_WIDTH'(10);
            UNITS_LD: conv_in = BIT_WIDTH'(u_reg);
            default:  conv_in = '0;
        endcase
    end

    bin2roman_base10 #(
        .BIT_WIDTH (BIT_WIDTH),
        .OUT_NUM   (OUT_NUM),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_conv (
        .value (conv_in),
        .roman (conv_out)
    );

    genvar gi;
    generate
        for (gi = 0; gi < OUT_NUM; gi++) begin : g_slot
            assign slot_nonnull[gi] = |conv_out[gi*OUT_WIDTH +: OUT_WIDTH];
            assign slot_arr[gi]     = symbuf_reg[gi*OUT_WIDTH +: OUT_WIDTH];
        end
    endgenerate

    // Symbol count of the fresh conversion = highest occupied slot + 1.
    always_comb begin
        top_cnt = 3'd0;
        for (int i = 0; i < OUT_NUM; i++) begin
            if (slot_nonnull[i]) begin
                top_cnt = 3'(i + 1);
            end
        end
    end

    // Output decode uses registered state only; sym_ready does not reach
    // sym_valid/sym_data/sym_last.
    always_comb begin
        slot_sel = cnt_reg - 3'd1;
        cur_sym  = SYM_NULL;
        if (cnt_reg != 3'd0 && 32'(slot_sel) < OUT_NUM) begin
            cur_sym = slot_arr[slot_sel];
        end
    end

    assign emit      = (state_reg == TENS_EMIT) || (state_reg == UNITS_EMIT);
    assign last_slot = (cnt_reg == 3'd1);
    assign beat      = bus.sym_valid && bus.sym_ready;

    assign bus.sym_valid = emit || (state_reg == ZERO);
    assign bus.sym_data  = emit ? cur_sym : SYM_NULL;
    assign bus.sym_last  = (state_reg == ZERO)
                         || ((state_reg == UNITS_EMIT) && last_slot)
                         || ((state_reg == TENS_EMIT) && last_slot && (u_reg == 4'd0));
    assign bus.in_ready  = (state_reg == IDLE);
    assign busy          = (state_reg != IDLE);

    always_comb begin
        state_next  = state_reg;
        t_next      = t_reg;
        u_next      = u_reg;
        symbuf_next = symbuf_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    t_next = 3'(bus.in_data / BIT_WIDTH'(10));
                    u_next = 4'(bus.in_data % BIT_WIDTH'(10));
                    if (t_next != 3'd0) begin
                        state_next = TENS_LD;
                    end else if (u_next != 4'd0) begin
                        state_next = UNITS_LD;
                    end else begin
                        state_next = ZERO;
                    end
                end
            end
            TENS_LD: begin
                symbuf_next = conv_out;
                cnt_next    = top_cnt;
                state_next  = TENS_EMIT;
            end
            UNITS_LD: begin
                symbuf_next = conv_out;
                cnt_next    = top_cnt;
                state_next  = UNITS_EMIT;
            end
            TENS_EMIT: begin
                if (beat) begin
                    cnt_next = cnt_reg - 3'd1;
                    if (last_slot) begin
                        state_next = (u_reg != 4'd0) ? UNITS_LD : IDLE;
                    end
                end
            end
            UNITS_EMIT: begin
                if (beat) begin
                    cnt_next = cnt_reg - 3'd1;
                    if (last_slot) begin
                        state_next = IDLE;
                    end
                end
            end
            ZERO: begin
                if (bus.sym_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            t_reg      <= '0;
            u_reg      <= '0;
            symbuf_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            t_reg      <= t_next;
            u_reg      <= u_next;
            symbuf_reg <= symbuf_next;
            cnt_reg    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_roman_symbol_streamer.sv
// ---------------------------------------------------------------------------
// tb_roman_symbol_streamer
// Self-checking bench: reference Roman strings from digit tables, beats
// compared in order, timing checked when sym_ready is held high.
// ---------------------------------------------------------------------------
module tb_roman_symbol_streamer;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    roman_symbol_streamer_if #(.BIT_WIDTH(6), .OUT_WIDTH(3)) bus ();

    roman_symbol_streamer #(
        .BIT_WIDTH (6),
        .OUT_NUM   (6),
        .OUT_WIDTH (3)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic string tens_str(input int d);
        case (d)
            1: return "X";
            2: return "XX";
            3: return "XXX";
            4: return "XL";
            5: return "L";
            6: return "LX";
            default: return "";
        endcase
    endfunction

    function automatic string units_str(input int d);
        case (d)
            1: return "I";
            2: return "II";
            3: return "III";
            4: return "IV";
            5: return "V";
            6: return "VI";
            7: return "VII";
            8: return "VIII";
            9: return "IX";
            default: return "";
        endcase
    endfunction

    function automatic int sym_code(input byte c);
        case (c)
            "I": return 1;
            "V": return 2;
            "X": return 3;
            "L": return 4;
            default: return 0;
        endcase
    endfunction

    // mode 0: ready always high (timing checked)
    // mode 1: random ready
    // mode 2: ready low for the first cycles, then high (cnt hold checked)
    // abort_at >= 0: assert rst once that many beats have been taken
    task automatic run_number(input int v, input int mode, input int abort_at);
        string ts, us, s;
        int nt, nu, n, lat, k, r, wait_cnt, exp_r, exp_cnt;
        int exp_sym[$];
        bit prev_stall, aborted;
        int prev_data, prev_last;

        ts = tens_str(v / 10);
        us = units_str(v % 10);
        s  = {ts, us};
        nt = ts.len();
        nu = us.len();
        exp_sym.delete();
        if (v == 0) begin
            exp_sym.push_back(0);
        end else begin
            for (int i = 0; i < s.len(); i++) exp_sym.push_back(sym_code(s[i]));
        end
        n   = exp_sym.size();
        lat = (v == 0) ? 0 : 1;

        @(negedge clk);
        wait_cnt = 0;
        while (!bus.in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!bus.in_ready) begin
            check_eq("accept_timeout", 0, 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 6'(v);
        @(posedge clk);

        k = 0;
        r = 0;
        prev_stall = 1'b0;
        prev_data  = 0;
        prev_last  = 0;
        aborted    = 1'b0;
        while (k < n && r < 200) begin
            #1;
            case (mode)
                0:       bus.sym_ready = 1'b1;
                1:       bus.sym_ready = ($urandom_range(0, 3) != 0);
                default: bus.sym_ready = (r >= 6);
            endcase
            // Offer values mid-stream; none may be accepted.
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 6'($urandom_range(0, 63));
            @(negedge clk);
            if (abort_at >= 0 && k == abort_at) begin
                rst = 1'b1;
                bus.in_valid = 1'b0;
                #1;
                check_eq("abort_sym_valid", int'(bus.sym_valid), 0);
                check_eq("abort_in_ready", int'(bus.in_ready), 1);
                check_eq("abort_busy", int'(busy), 0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            check_eq("busy_mid", int'(busy), 1);
            check_eq("in_ready_mid", int'(bus.in_ready), 0);
            if (bus.sym_valid && prev_stall) begin
                check_eq("hold_data", int'(bus.sym_data), prev_data);
                check_eq("hold_last", int'(bus.sym_last), prev_last);
            end
            if (bus.sym_valid && bus.sym_ready) begin
                check_eq("sym_data", int'(bus.sym_data), exp_sym[k]);
                check_eq("sym_last", int'(bus.sym_last), (k == n - 1) ? 1 : 0);
                if (mode == 0) begin
                    exp_r = lat + k + ((nt > 0 && nu > 0 && k >= nt) ? 1 : 0);
                    check_eq("beat_cycle", r, exp_r);
                end
                k++;
                if (k == n) bus.in_valid = 1'b0;
                prev_stall = 1'b0;
            end else begin
                prev_stall = bus.sym_valid;
                prev_data  = int'(bus.sym_data);
                prev_last  = int'(bus.sym_last);
                if (mode == 2 && bus.sym_valid) begin
                    exp_cnt = (k < nt) ? (nt - k) : (n - k);
                    check_eq("cnt_hold", int'(dut.cnt_reg), exp_cnt);
                end
            end
            r++;
            @(posedge clk);
        end
        bus.in_valid = 1'b0;
        if (aborted) begin
            $display("value %0d aborted by reset after %0d beats", v, k);
            return;
        end
        if (k < n) check_eq("beat_timeout", k, n);
        @(negedge clk);
        check_eq("in_ready_after", int'(bus.in_ready), 1);
        check_eq("sym_valid_after", int'(bus.sym_valid), 0);
        $display("value %0d '%s' mode %0d: %0d beats in %0d cycles", v, s, mode, k, r);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sym_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", int'(bus.in_ready), 1);
        check_eq("rst_sym_valid", int'(bus.sym_valid), 0);
        check_eq("rst_sym_data", int'(bus.sym_data), 0);
        check_eq("rst_sym_last", int'(bus.sym_last), 0);
        check_eq("rst_busy", int'(busy), 0);
        rst = 1'b0;

        run_number(14, 0, -1);
        run_number(38, 0, -1);
        run_number(0, 0, -1);
        run_number(50, 0, -1);
        run_number(4, 2, -1);
        run_number(38, 0, 4);
        run_number(9, 0, -1);

        for (int v = 0; v < 64; v++) run_number(v, 0, -1);
        for (int i = 0; i < 40; i++) run_number($urandom_range(0, 63), 1, -1);
        for (int i = 0; i < 5; i++) run_number($urandom_range(0, 63), 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
